// File: rtl/jtframe_lfbuf_pkg.sv
// Shared definitions for the line-frame-buffer blocks (DDR controller and scan-out).
package jtframe_lfbuf_pkg;

   localparam int unsigned LFBUF_HW = 9;
   localparam int unsigned LFBUF_DW = 16;
   localparam logic [15:0] LFBUF_BLANK = 16'h0;

   typedef enum logic {BankA = 1'b0, BankB = 1'b1} bank_e;

   function automatic bank_e other_bank(bank_e b);
      return (b == BankA) ? BankB : BankA;
   endfunction

endpackage

// File: rtl/jtframe_lfbuf_scan_if.sv
// Fill bus from the DDR controller into the scan-out line RAMs.
interface jtframe_lfbuf_scan_if
   import jtframe_lfbuf_pkg::*;
#(
   parameter int unsigned HW = LFBUF_HW,
   parameter int unsigned DW = LFBUF_DW
);
   logic          scr_we;
   logic [HW-1:0] rd_addr;
   logic [DW-1:0] fb_dout;

   modport master (output scr_we, rd_addr, fb_dout);
   modport slave  (input  scr_we, rd_addr, fb_dout);
endinterface

// File: rtl/jtframe_lfbuf_scan_bank.sv
// One line of pixel storage: simple dual-port RAM, one write port, registered read port.
module jtframe_lfbuf_scan_bank #(
   parameter int unsigned HW = 9,
   parameter int unsigned DW = 16
) (
   input  logic          clk,
   input  logic          we,
   input  logic [HW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [HW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [2**HW];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/jtframe_lfbuf_scan.sv
// Scan-out stage: ping-pong line RAMs filled by the DDR controller, played back on pxl_cen
// and erased behind the read pointer so undelivered lines come out as BLANK.
module jtframe_lfbuf_scan
   import jtframe_lfbuf_pkg::*;
#(
   parameter int unsigned HW    = LFBUF_HW,
   parameter int unsigned DW    = LFBUF_DW,
   parameter logic [DW-1:0] BLANK = LFBUF_BLANK
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pxl_cen,
   input  logic                  lhbl,
   input  logic                  lvbl,
   jtframe_lfbuf_scan_if.slave   fill,
   output logic [DW-1:0]         pxl,
   output logic                  pxl_vld,
   output logic                  wbank,
   output logic                  underrun,
   output logic [HW:0]           wr_cnt
);
   localparam logic [HW:0] FULL = {1'b1, {HW{1'b0}}};

   bank_e         wbank_q;
   logic          lhbl_l, lvbl_sw, rd_pend, rd_bank, ers_en;
   logic [HW-1:0] hcnt, ers_addr;
   logic [DW-1:0] rdata [2];
   logic          swap, rd;

   assign swap  = lhbl_l & ~lhbl;
   assign rd    = pxl_cen & lhbl & lvbl;
   assign wbank = wbank_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wbank_q  <= BankA;
         lhbl_l   <= 1'b0;
         lvbl_sw  <= 1'b0;
         underrun <= 1'b0;
         wr_cnt   <= '0;
         hcnt     <= '0;
         ers_en   <= 1'b0;
         ers_addr <= '0;
         rd_pend  <= 1'b0;
         rd_bank  <= 1'b0;
         pxl      <= BLANK;
         pxl_vld  <= 1'b0;
      end else begin
         lhbl_l <= lhbl;
         if (swap) begin
            wbank_q  <= other_bank(wbank_q);
            hcnt     <= '0;
            // Lines whose fill started in vblank are not expected to be complete
            underrun <= underrun | (lvbl_sw & (wr_cnt != FULL));
            lvbl_sw  <= lvbl;
            wr_cnt   <= '0;
         end else begin
            if (fill.scr_we && wr_cnt != FULL) wr_cnt <= wr_cnt + 1'b1;
            if (rd) hcnt <= hcnt + 1'b1;
         end
         ers_en   <= rd;
         ers_addr <= hcnt;
         if (rd) rd_bank <= ~wbank_q;
         if (pxl_cen) begin
            // Data read on the previous cen is shown now, even if blanking has begun
            rd_pend <= rd;
            pxl     <= rd_pend ? rdata[rd_bank] : BLANK;
            pxl_vld <= rd_pend;
         end
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      localparam bank_e ThisBank = (b == 0) ? BankA : BankB;
      logic fill_sel;
      assign fill_sel = (wbank_q == ThisBank);

      jtframe_lfbuf_scan_bank #(
         .HW (HW),
         .DW (DW)
      ) u_bank (
         .clk   (clk),
         .we    (fill_sel ? fill.scr_we  : ers_en),
         .waddr (fill_sel ? fill.rd_addr : ers_addr),
         .wdata (fill_sel ? fill.fb_dout : BLANK),
         .re    (rd & ~fill_sel),
         .raddr (hcnt),
         .rdata (rdata[b])
      );
   end
endmodule

// File: tb/tb_jtframe_lfbuf_scan.sv
// Self-checking bench for jtframe_lfbuf_scan: reference line-RAM model plus pixel scoreboard.
module tb_jtframe_lfbuf_scan;
   localparam logic [15:0] BLANK = 16'h0;

   logic        clk = 1'b0;
   logic        rst_n, pxl_cen, lhbl, lvbl;
   logic [15:0] pxl;
   logic        pxl_vld, wbank, underrun;
   logic [9:0]  wr_cnt;

   jtframe_lfbuf_scan_if #(.HW(9), .DW(16)) fill_if ();

   jtframe_lfbuf_scan #(.HW(9), .DW(16), .BLANK(BLANK)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .pxl_cen  (pxl_cen),
      .lhbl     (lhbl),
      .lvbl     (lvbl),
      .fill     (fill_if.slave),
      .pxl      (pxl),
      .pxl_vld  (pxl_vld),
      .wbank    (wbank),
      .underrun (underrun),
      .wr_cnt   (wr_cnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // Reference model
   logic [15:0] mram [2][512];
   bit          mval [2][512];
   bit          mwb, mhbl_l, mlvsw, mpend, mund;
   int          mwr, mh;
   logic [16:0] sbq [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mwb = 0; mhbl_l = 0; mlvsw = 0; mpend = 0; mund = 0; mwr = 0; mh = 0;
      sbq.delete();
      for (int b = 0; b < 2; b++)
         for (int k = 0; k < 512; k++) mval[b][k] = 0;
   endtask

   // One clk cycle: drive, advance model, clock, compare pixel output on cen
   task automatic cyc(input bit cen, input bit hb, input bit vb, input bit we, input int a,
                      input logic [15:0] d);
      bit          sw, rd, exp_vld, do_pix;
      logic [15:0] exp_pix;
      logic [16:0] e;
      pxl_cen = cen; lhbl = hb; lvbl = vb;
      fill_if.scr_we = we; fill_if.rd_addr = a[8:0]; fill_if.fb_dout = d;
      sw = mhbl_l && !hb;
      rd = cen && hb && vb;
      exp_vld = 0; exp_pix = BLANK; do_pix = 1;
      if (we) begin mram[mwb][a] = d; mval[mwb][a] = 1; end
      if (cen) begin
         exp_vld = mpend;
         if (mpend) begin
            e = sbq.pop_front();
            exp_pix = e[15:0];
            do_pix = e[16];
         end
         if (rd) begin
            sbq.push_back({mval[!mwb][mh], mram[!mwb][mh]});
            mram[!mwb][mh] = BLANK; mval[!mwb][mh] = 1;
            mh = (mh + 1) % 512;
         end
         mpend = rd;
      end
      if (sw) begin
         mund = mund | (mlvsw && mwr != 512);
         mlvsw = vb; mwr = 0; mwb = !mwb; mh = 0;
      end else if (we && mwr < 512) mwr++;
      mhbl_l = hb;
      @(posedge clk); #1;
      if (cen) begin
         check("pxl_vld", 32'(pxl_vld), 32'(exp_vld));
         if (do_pix) check("pxl", 32'(pxl), 32'(exp_pix));
      end
   endtask

   // 512 active cens (cen every other clk) then 8 blank cens; swap on first blank cycle
   task automatic line(input bit vact, input bit vend, input int nfill, input logic [15:0] seed,
                       input bit coll);
      for (int i = 0; i < 1024; i++)
         cyc(i % 2 == 0, 1'b1, vact, i < nfill, i % 512, seed ^ 16'(i));
      check("wr_cnt_pre_swap", 32'(wr_cnt), 32'(mwr));
      for (int j = 0; j < 16; j++) begin
         cyc(j % 2 == 0, 1'b0, vend, coll && j == 0, 5, 16'hBEEF);
         if (j == 0) begin
            check("wbank_swap", 32'(wbank), 32'(mwb));
            check("wr_cnt_swap", 32'(wr_cnt), 32'(mwr));
            check("underrun_swap", 32'(underrun), 32'(mund));
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; pxl_cen = 0; lhbl = 0; lvbl = 0;
      fill_if.scr_we = 0; fill_if.rd_addr = '0; fill_if.fb_dout = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_pxl", 32'(pxl), 32'(BLANK));
      check("rst_vld", 32'(pxl_vld), 0);
      check("rst_wbank", 32'(wbank), 0);
      check("rst_underrun", 32'(underrun), 0);
      check("rst_wr_cnt", 32'(wr_cnt), 0);
      rst_n = 1'b1;

      // Full fill with data=addr, then play it back (bank 1 content unknown on first line)
      line(1, 1, 512, 16'h0000, 0);
      check("full_wbank", 32'(wbank), 1);
      check("full_underrun", 32'(underrun), 0);
      // Play 0..511; collision write lands in the bank about to be shown
      line(1, 1, 512, 16'hA5A5, 1);
      check("coll_wr_cnt", 32'(wr_cnt), 0);
      // Show BEEF at pixel 5; lvbl falls with this line's swap
      line(1, 0, 512, 16'h3C00, 0);
      for (int v = 0; v < 15; v++) line(0, 0, 0, 16'h0, 0);
      line(0, 1, 0, 16'h0, 0);
      check("vblank_underrun", 32'(underrun), 0);
      // Short fill flags underrun
      line(1, 1, 300, 16'h5000, 0);
      check("short_underrun", 32'(underrun), 1);
      // Pixels 300..511 erased; no refill of the other bank
      line(1, 1, 0, 16'h0, 0);
      // Erased bank replayed: all BLANK
      line(1, 1, 700, 16'h6100, 0);
      line(1, 1, 512, 16'h0F0F, 0);
      check("sticky_underrun", 32'(underrun), 1);

      // Async reset mid-playback at hcnt=200
      for (int i = 0; i < 400; i++)
         cyc(i % 2 == 0, 1'b1, 1'b1, 1'b1, i % 512, 16'h7000 ^ 16'(i));
      #2 rst_n = 1'b0;
      #1;
      check("arst_pxl", 32'(pxl), 32'(BLANK));
      check("arst_vld", 32'(pxl_vld), 0);
      check("arst_wbank", 32'(wbank), 0);
      check("arst_underrun", 32'(underrun), 0);
      check("arst_wr_cnt", 32'(wr_cnt), 0);
      pxl_cen = 0; lhbl = 0; fill_if.scr_we = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      line(1, 1, 512, 16'h1234, 0);
      check("post_rst_wbank", 32'(wbank), 1);
      line(1, 1, 512, 16'h4321, 0);
      check("post_rst_underrun", 32'(underrun), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
